// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter
//   Shares the 8-digit seven-segment display controller between three
//   sources. Source 0 is the urgent channel and preempts the normal
//   channels (1, 2). Normal owners rotate round-robin once they have held
//   the display for HOLD_MS ms and a competing normal source is waiting.
//   There is a one-cycle dead (blank) cycle between owners.
// Ports:
//   clk, reset                 clock, async active-high reset
//   req[2:0]                   request level per source
//   srcN_digits[39:0]          packed digit codes, [4:0]=d0 .. [39:35]=d7
//   srcN_dp[7:0]               decimal points per source
//   gnt[2:0]                   one-hot grant, 0 when no owner
//   owner[1:0]                 owner index, 3 when none
//   d0..d7[4:0], dp[7:0]       registered display data, blank (23) when idle
module seg_display_arbiter #(
  parameter int CLK_FREQUENCY_HZ  = 100000000,
  parameter int HOLD_MS           = 2000,
  parameter int SIMULATE          = 0,
  parameter int SIMULATE_TICK_CNT = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  req,
  input  logic [39:0] src0_digits,
  input  logic [39:0] src1_digits,
  input  logic [39:0] src2_digits,
  input  logic [7:0]  src0_dp,
  input  logic [7:0]  src1_dp,
  input  logic [7:0]  src2_dp,
  output logic [2:0]  gnt,
  output logic [1:0]  owner,
  output logic [4:0]  d0,
  output logic [4:0]  d1,
  output logic [4:0]  d2,
  output logic [4:0]  d3,
  output logic [4:0]  d4,
  output logic [4:0]  d5,
  output logic [4:0]  d6,
  output logic [4:0]  d7,
  output logic [7:0]  dp
);

  localparam int TICK_TOP = (SIMULATE != 0) ? SIMULATE_TICK_CNT
                                            : CLK_FREQUENCY_HZ / 1000 - 1;
  localparam int TW = (TICK_TOP > 0) ? $clog2(TICK_TOP + 1) : 1;
  localparam int HW = (HOLD_MS > 0) ? $clog2(HOLD_MS + 1) : 1;
  localparam logic [4:0] BLANK = 5'd23;

  typedef enum logic [1:0] {IDLE, OWN, SWITCH} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tick_cnt_q;
  logic          tick;
  logic [1:0]    owner_q, owner_d;
  logic [1:0]    last_q, last_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [39:0]   dig_q, dig_d;
  logic [7:0]    dp_q, dp_d;
  logic [1:0]    pick;
  logic [39:0]   src_dig;
  logic [7:0]    src_dp;
  logic          own_req;
  logic          competitor;

  // Free-running ms tick.
  assign tick = (tick_cnt_q == TW'(TICK_TOP));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     tick_cnt_q <= '0;
    else if (tick) tick_cnt_q <= '0;
    else           tick_cnt_q <= tick_cnt_q + TW'(1);
  end

  // Arbitration: req[0] wins outright; otherwise search from last+1.
  // With req[0] low only sources 1 and 2 remain, so each start point
  // collapses to a two-way choice.
  always_comb begin
    pick = 2'd0;
    if (!req[0]) begin
      case (last_q)
        2'd1:    pick = req[2] ? 2'd2 : 2'd1;
        default: pick = req[1] ? 2'd1 : 2'd2;
      endcase
    end
  end

  // Owner's source data and request level.
  always_comb begin
    case (owner_q)
      2'd0: begin src_dig = src0_digits; src_dp = src0_dp; own_req = req[0]; end
      2'd1: begin src_dig = src1_digits; src_dp = src1_dp; own_req = req[1]; end
      default: begin src_dig = src2_digits; src_dp = src2_dp; own_req = req[2]; end
    endcase
  end

  // The other normal source (only meaningful while a normal source owns).
  assign competitor = (owner_q == 2'd1) ? req[2] : req[1];

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE, SWITCH: begin
        if (req != 3'b000) begin
          state_d = OWN;
          owner_d = pick;
          hold_d  = '0;
        end else begin
          state_d = IDLE;
        end
      end
      OWN: begin
        if (tick && hold_q < HW'(HOLD_MS)) hold_d = hold_q + HW'(1);
        if (!own_req ||
            (owner_q != 2'd0 &&
             (req[0] || (hold_q >= HW'(HOLD_MS) && competitor)))) begin
          state_d = SWITCH;
          last_d  = owner_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Display data only follows the owner while it stays owner, so the
  // first OWN cycle and the SWITCH cycle both show blank.
  always_comb begin
    dig_d = {8{BLANK}};
    dp_d  = 8'h00;
    if (state_q == OWN && state_d == OWN) begin
      dig_d = src_dig;
      dp_d  = src_dp;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= 2'd3;
      last_q  <= 2'd2;
      hold_q  <= '0;
      dig_q   <= {8{BLANK}};
      dp_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      dig_q   <= dig_d;
      dp_q    <= dp_d;
    end
  end

  assign gnt   = (state_q == OWN) ? 3'(3'b001 << owner_q) : 3'b000;
  assign owner = (state_q == OWN) ? owner_q : 2'd3;
  assign d0 = dig_q[4:0];
  assign d1 = dig_q[9:5];
  assign d2 = dig_q[14:10];
  assign d3 = dig_q[19:15];
  assign d4 = dig_q[24:20];
  assign d5 = dig_q[29:25];
  assign d6 = dig_q[34:30];
  assign d7 = dig_q[39:35];
  assign dp = dp_q;

endmodule
